// File: rtl/mem_access_pkg.sv
// mem_access_pkg: opcode constants, FSM state and access-size encodings for the memory-access stage.
//   op_size(): maps a load/store opcode to its access width.
package mem_access_pkg;
   localparam logic [5:0] OP_RTYPE   = 6'h00;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_LB      = 6'h20;
   localparam logic [5:0] OP_LH      = 6'h21;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_LBU     = 6'h24;
   localparam logic [5:0] OP_LHU     = 6'h25;
   localparam logic [5:0] OP_SB      = 6'h28;
   localparam logic [5:0] OP_SH      = 6'h29;
   localparam logic [5:0] OP_SW      = 6'h2B;
   localparam logic [5:0] FUNCT_JALR = 6'h09;

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
   typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} size_t;

   function automatic size_t op_size(input logic [5:0] op);
      return (op == OP_LB || op == OP_LBU || op == OP_SB) ? SZ_B :
             (op == OP_LH || op == OP_LHU || op == OP_SH) ? SZ_H : SZ_W;
   endfunction
endpackage

// File: rtl/mem_access_load_align.sv
// load_align: extracts the addressed byte/half/word from a read word and sign- or zero-extends it.
//   rdata in 32 read word, off in 2 byte offset, size in access width,
//   sgn in 1 sign-extend when high, val out 32 extended result.
module load_align
   import mem_access_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  off,
   input  size_t       size,
   input  logic        sgn,
   output logic [31:0] val
);
   logic [7:0]  b;
   logic [15:0] h;
   always_comb begin
      b   = rdata[{off, 3'b000} +: 8];
      h   = off[1] ? rdata[31:16] : rdata[15:0];
      val = size == SZ_B ? {{24{sgn & b[7]}}, b} :
            size == SZ_H ? {{16{sgn & h[15]}}, h} : rdata;
   end
endmodule

// File: rtl/mem_access.sv
// mem_access: MIPS memory-access stage driving a req/ack data bus and producing write-back data.
//   CLK/RST clock and async active-low reset; Ins/Adr/Wdata/nextPC from EX;
//   Rdata write-back value; Stall holds fetch and register write; Misalign/BusErr error pulses;
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata registered bus request; mem_rdata/mem_ack bus response.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int TO_W    = 5
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] Ins,
   input  logic [31:0] Adr,
   input  logic [31:0] Wdata,
   input  logic [31:0] nextPC,
   output logic [31:0] Rdata,
   output logic        Stall,
   output logic        Misalign,
   output logic        BusErr,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   state_t          state, state_n;
   size_t           sz, sz_q;
   logic [5:0]      op;
   logic            is_ld, is_st, is_mem, is_link, mis;
   logic [3:0]      be;
   logic [31:0]     wd, rdata_q, ld_val;
   logic [1:0]      off_q;
   logic            sgn_q, ld_q, buserr_q;
   logic [TO_W-1:0] cnt;
   logic            unused_ins;

   assign op         = Ins[31:26];
   assign unused_ins = ^Ins[25:6];
   assign is_ld      = op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
   assign is_st      = op inside {OP_SB, OP_SH, OP_SW};
   assign is_mem     = is_ld | is_st;
   assign is_link    = op == OP_JAL || (op == OP_RTYPE && Ins[5:0] == FUNCT_JALR);
   assign sz         = op_size(op);
   assign mis        = (sz == SZ_W && Adr[1:0] != 2'b00) || (sz == SZ_H && Adr[0]);
   assign be         = sz == SZ_B ? 4'b0001 << Adr[1:0] :
                       sz == SZ_H ? (Adr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   assign wd         = sz == SZ_B ? {4{Wdata[7:0]}} : sz == SZ_H ? {2{Wdata[15:0]}} : Wdata;
   assign BusErr     = buserr_q;

   load_align u_align (
      .rdata(rdata_q),
      .off  (off_q),
      .size (sz_q),
      .sgn  (sgn_q),
      .val  (ld_val)
   );

   always_comb begin
      state_n  = state;
      Stall    = 1'b0;
      Misalign = 1'b0;
      Rdata    = Adr;
      case (state)
         IDLE: begin
            if (is_mem && mis) begin
               Misalign = RST;
               Rdata    = 32'd0;
            end else if (is_mem) begin
               Stall   = 1'b1;
               state_n = BUSY;
            end else
               Rdata = is_link ? nextPC : Adr;
         end
         BUSY: begin
            Stall   = 1'b1;
            state_n = (mem_ack || cnt == TO_LAST) ? DONE : BUSY;
         end
         DONE: begin
            Rdata   = ld_q ? ld_val : Adr;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'd0;
         mem_be    <= 4'd0;
         mem_wdata <= 32'd0;
         rdata_q   <= 32'd0;
         cnt       <= '0;
         buserr_q  <= 1'b0;
         sz_q      <= SZ_W;
         off_q     <= 2'd0;
         sgn_q     <= 1'b0;
         ld_q      <= 1'b0;
      end else begin
         state    <= state_n;
         buserr_q <= state == BUSY && !mem_ack && cnt == TO_LAST;
         if (state == IDLE && is_mem && !mis) begin
            mem_req   <= 1'b1;
            mem_we    <= is_st;
            mem_addr  <= {Adr[31:2], 2'b00};
            mem_be    <= be;
            mem_wdata <= wd;
            sz_q      <= sz;
            off_q     <= Adr[1:0];
            sgn_q     <= op == OP_LB || op == OP_LH;
            ld_q      <= is_ld;
            cnt       <= '0;
         end else if (state == BUSY && mem_ack) begin
            mem_req <= 1'b0;
            rdata_q <= mem_rdata;
         end else if (state == BUSY && cnt == TO_LAST) begin
            mem_req <= 1'b0;
            rdata_q <= 32'd0;
         end else if (state == BUSY)
            cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed scoreboard bench for mem_access (loads, stores, misalign, timeout, link, reset).
module tb_mem_access;
   logic        CLK = 1'b0, RST;
   logic [31:0] Ins, Adr, Wdata, nextPC, mem_rdata;
   logic        mem_ack;
   logic [31:0] Rdata, mem_addr, mem_wdata;
   logic        Stall, Misalign, BusErr, mem_req, mem_we;
   logic [3:0]  mem_be;

   string       tq[$];
   logic [31:0] vq[$];
   int          checks = 0, passed = 0;

   mem_access #(.TIMEOUT(16), .TO_W(5)) dut (
      .CLK(CLK), .RST(RST), .Ins(Ins), .Adr(Adr), .Wdata(Wdata), .nextPC(nextPC),
      .Rdata(Rdata), .Stall(Stall), .Misalign(Misalign), .BusErr(BusErr),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] fn);
      return {op, 20'd0, fn};
   endfunction

   task automatic push(input string t, input logic [31:0] v);
      tq.push_back(t);
      vq.push_back(v);
   endtask

   task automatic check(input logic [31:0] obs);
      string       t;
      logic [31:0] e;
      checks++;
      if (tq.size() == 0) begin
         $error("FAIL sb_underflow obs=%h exp=none", obs);
         return;
      end
      t = tq.pop_front();
      e = vq.pop_front();
      assert (obs === e) passed++;
      else $error("FAIL %s obs=%h exp=%h", t, obs, e);
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic smp();
      @(negedge CLK);
   endtask

   // IDLE launch cycle, one BUSY cycle with ack, then the DONE cycle.
   task automatic txn(input string t, input logic [31:0] ins, adr, wd, rd,
                      input logic [3:0] be, input logic we, input logic [31:0] wdat, res);
      cyc();
      Ins = ins; Adr = adr; Wdata = wd; mem_ack = 1'b0;
      push({t, "_idle_stall"}, 1); push({t, "_idle_req"}, 0);
      smp(); check(Stall); check(mem_req);
      cyc();
      mem_ack = 1'b1; mem_rdata = rd;
      push({t, "_req"}, 1); push({t, "_addr"}, {adr[31:2], 2'b00}); push({t, "_be"}, be);
      push({t, "_we"}, we); push({t, "_busy_stall"}, 1);
      if (we) push({t, "_wdata"}, wdat);
      smp(); check(mem_req); check(mem_addr); check(mem_be); check(mem_we); check(Stall);
      if (we) check(mem_wdata);
      cyc();
      mem_ack = 1'b0;
      push({t, "_done_stall"}, 0); push({t, "_rdata"}, res); push({t, "_done_req"}, 0);
      push({t, "_done_buserr"}, 0);
      smp(); check(Stall); check(Rdata); check(mem_req); check(BusErr);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog obs=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b0; Ins = 32'd0; Adr = 32'd0; Wdata = 32'd0; nextPC = 32'd0;
      mem_rdata = 32'd0; mem_ack = 1'b0;
      push("rst_req", 0); push("rst_we", 0); push("rst_addr", 0); push("rst_be", 0);
      push("rst_wdata", 0); push("rst_buserr", 0); push("rst_misalign", 0);
      smp(); smp();
      check(mem_req); check(mem_we); check(mem_addr); check(mem_be);
      check(mem_wdata); check(BusErr); check(Misalign);
      cyc();
      RST = 1'b1;

      txn("lw",  mk(6'h23, 0), 32'h10, 32'h0,         32'hDEAD_BEEF, 4'hF,    0, 32'h0,         32'hDEAD_BEEF);
      txn("lb",  mk(6'h20, 0), 32'h13, 32'h0,         32'h8000_0000, 4'b1000, 0, 32'h0,         32'hFFFF_FF80);
      txn("lbu", mk(6'h24, 0), 32'h13, 32'h0,         32'h8000_0000, 4'b1000, 0, 32'h0,         32'h0000_0080);
      txn("lh",  mk(6'h21, 0), 32'h02, 32'h0,         32'h8001_1234, 4'b1100, 0, 32'h0,         32'hFFFF_8001);
      txn("lhu", mk(6'h25, 0), 32'h00, 32'h0,         32'h8001_F234, 4'b0011, 0, 32'h0,         32'h0000_F234);
      txn("sh",  mk(6'h29, 0), 32'h22, 32'h1234_ABCD, 32'h0,         4'b1100, 1, 32'hABCD_ABCD, 32'h22);
      txn("sb",  mk(6'h28, 0), 32'h41, 32'h0000_005A, 32'h0,         4'b0010, 1, 32'h5A5A_5A5A, 32'h41);
      txn("sw",  mk(6'h2B, 0), 32'h40, 32'hCAFE_F00D, 32'h0,         4'hF,    1, 32'hCAFE_F00D, 32'h40);

      cyc();
      Ins = mk(6'h2B, 0); Adr = 32'h05; Wdata = 32'h1111_2222;
      push("sw_mis_flag", 1); push("sw_mis_stall", 0); push("sw_mis_req", 0); push("sw_mis_rdata", 0);
      smp(); check(Misalign); check(Stall); check(mem_req); check(Rdata);
      cyc();
      Ins = mk(6'h21, 0); Adr = 32'h03;
      push("lh_mis_flag", 1); push("lh_mis_req", 0);
      smp(); check(Misalign); check(mem_req);
      cyc();
      Ins = mk(6'h00, 6'h20); Adr = 32'h07;
      push("mis_clear", 0); push("alu_stall", 0); push("alu_rdata", 32'h07); push("alu_req", 0);
      smp(); check(Misalign); check(Stall); check(Rdata); check(mem_req);

      cyc();
      Ins = mk(6'h23, 0); Adr = 32'h100;
      push("to_idle_stall", 1);
      smp(); check(Stall);
      for (int i = 0; i < 16; i++) begin
         cyc();
         push($sformatf("to_req_%0d", i), 1); push($sformatf("to_stall_%0d", i), 1);
         push($sformatf("to_buserr_%0d", i), 0);
         smp(); check(mem_req); check(Stall); check(BusErr);
      end
      cyc();
      mem_ack = 1'b1;
      push("to_done_req", 0); push("to_done_buserr", 1); push("to_done_stall", 0);
      push("to_done_rdata", 0); push("to_done_misalign", 0);
      smp(); check(mem_req); check(BusErr); check(Stall); check(Rdata); check(Misalign);
      cyc();
      Ins = mk(6'h00, 6'h21); Adr = 32'h33;
      push("to_after_buserr", 0); push("to_after_rdata", 32'h33); push("to_after_stall", 0);
      smp(); check(BusErr); check(Rdata); check(Stall);
      cyc();
      mem_ack = 1'b0;
      push("ack_idle_ignored_req", 0);
      smp(); check(mem_req);

      cyc();
      Ins = mk(6'h03, 0); nextPC = 32'h0040_0008; Adr = 32'h1234;
      push("jal_rdata", 32'h0040_0008); push("jal_stall", 0);
      smp(); check(Rdata); check(Stall);
      cyc();
      Ins = mk(6'h00, 6'h09); nextPC = 32'h0040_0100;
      push("jalr_rdata", 32'h0040_0100);
      smp(); check(Rdata);

      cyc();
      Ins = mk(6'h23, 0); Adr = 32'h200;
      cyc();
      push("rb_req", 1);
      smp(); check(mem_req);
      #1 RST = 1'b0;
      #1;
      push("rb_req_drop", 0); push("rb_be", 0);
      check(mem_req); check(mem_be);
      cyc();
      Ins = 32'd0; Adr = 32'h44; RST = 1'b1;
      push("rb_idle_stall", 0); push("rb_idle_req", 0); push("rb_idle_rdata", 32'h44);
      smp(); check(Stall); check(mem_req); check(Rdata);

      checks++;
      assert (tq.size() == 0) passed++;
      else $error("FAIL sb_leftover obs=%0d exp=0", tq.size());

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
